// File: rtl/sd_pkg.sv
// -----------------------------------------------------------------------------
// sd_pkg
// Shared definitions for the SD clock path.
//   SD_CLK_CONFIG_* : 2-bit configuration codes understood by the SD clock
//                     generator (also used for the CPU speed select field).
//   sd_clk_state_t  : states of the SD clock scheduler FSM.
// -----------------------------------------------------------------------------
package sd_pkg;

   localparam logic [1:0] SD_CLK_CONFIG_STOP    = 2'd0;
   localparam logic [1:0] SD_CLK_CONFIG_DIV_256 = 2'd1;
   localparam logic [1:0] SD_CLK_CONFIG_DIV_4   = 2'd2;
   localparam logic [1:0] SD_CLK_CONFIG_DIV_2   = 2'd3;

   typedef enum logic [1:0] {
      S_STOPPED  = 2'd0,
      S_INIT     = 2'd1,
      S_RUNNING  = 2'd2,
      S_STOPPING = 2'd3
   } sd_clk_state_t;

endpackage

// File: rtl/sd_clk_scheduler.sv
// -----------------------------------------------------------------------------
// sd_clk_scheduler
// Drives the SD clock generator configuration. Runs the card power-up
// sequence (INIT_CLOCKS slow clocks), starts the clock when the CMD or DAT
// engine requests it and stops it when both are idle. Speed changes and stops
// are only applied on a falling strobe (or while the pin is already idle low)
// so that no shortened high pulse ever reaches the card.
//
// Ports:
//   i_clk, i_reset             system clock, synchronous active-high reset
//   i_speed_sel[1:0]           requested run speed (SD_CLK_CONFIG_* encoding)
//   i_init_start               pulse: request the power-up clock sequence
//   i_cmd_req, i_dat_req       client clock requests (levels)
//   i_sd_clk                   current SD clock pin level
//   i_sd_clk_strobe_rising     generator strobe ahead of a rising edge
//   i_sd_clk_strobe_falling    generator strobe ahead of a falling edge
//   o_sd_clk_config[1:0]       configuration to the generator
//   o_clk_active               clock running at the requested speed
//   o_init_busy                power-up sequence pending or in progress
//   o_init_done                pulse at the end of the power-up sequence
// -----------------------------------------------------------------------------
module sd_clk_scheduler
   import sd_pkg::*;
#(
   parameter int INIT_CLOCKS = 80
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [1:0] i_speed_sel,
   input  logic       i_init_start,
   input  logic       i_cmd_req,
   input  logic       i_dat_req,
   input  logic       i_sd_clk,
   input  logic       i_sd_clk_strobe_rising,
   input  logic       i_sd_clk_strobe_falling,
   output logic [1:0] o_sd_clk_config,
   output logic       o_clk_active,
   output logic       o_init_busy,
   output logic       o_init_done
);

   // The init counter is 8 bits wide; larger parameter values wrap.
   localparam logic [7:0] INIT_TARGET = 8'(INIT_CLOCKS);

   sd_clk_state_t state_reg, state_next;
   logic [1:0]    cfg_reg, cfg_next;
   logic          active_reg, active_next;
   logic          busy_reg, busy_next;
   logic          done_reg, done_next;
   logic [7:0]    init_cnt_reg, init_cnt_next;
   logic          init_pending_reg, init_pending_next;
   logic          settled_reg, settled_next;
   logic          rise_d1_reg, rise_d2_reg;

   logic          rise_eff;
   logic          clk_req;
   logic          idle_low;

   // A simultaneous rising+falling strobe is treated as falling only.
   assign rise_eff = i_sd_clk_strobe_rising & ~i_sd_clk_strobe_falling;
   assign clk_req  = i_cmd_req | i_dat_req;
   // Pin low with no recent rising strobe: stopping now cannot cut a pulse.
   assign idle_low = ~i_sd_clk & ~rise_eff & ~rise_d1_reg & ~rise_d2_reg;

   always_comb begin
      state_next        = state_reg;
      cfg_next          = cfg_reg;
      init_cnt_next     = init_cnt_reg;
      done_next         = 1'b0;
      init_pending_next = init_pending_reg | (i_init_start & (state_reg != S_INIT));
      // settled_reg is high once S_STOPPED has been held for a full cycle;
      // a restart waits for it so the generator sees at least two STOP cycles.
      settled_next      = (state_reg == S_STOPPED);

      case (state_reg)
         S_STOPPED: begin
            cfg_next = SD_CLK_CONFIG_STOP;
            if (init_pending_reg) begin
               state_next        = S_INIT;
               cfg_next          = SD_CLK_CONFIG_DIV_256;
               init_cnt_next     = 8'd0;
               init_pending_next = 1'b0;
            end else if (clk_req && (i_speed_sel != SD_CLK_CONFIG_STOP) && settled_reg) begin
               state_next = S_RUNNING;
               cfg_next   = i_speed_sel;
            end
         end

         S_INIT: begin
            if (rise_eff && (init_cnt_reg != INIT_TARGET)) begin
               init_cnt_next = init_cnt_reg + 8'd1;
            end
            if ((init_cnt_reg == INIT_TARGET) && i_sd_clk_strobe_falling) begin
               state_next = S_STOPPED;
               cfg_next   = SD_CLK_CONFIG_STOP;
               done_next  = 1'b1;
            end
         end

         S_RUNNING: begin
            if (!clk_req || (i_speed_sel != cfg_reg) || init_pending_reg) begin
               state_next = S_STOPPING;
            end
         end

         S_STOPPING: begin
            // Renewed requests do not abort the stop; restart goes via S_STOPPED.
            if (i_sd_clk_strobe_falling || idle_low) begin
               state_next = S_STOPPED;
               cfg_next   = SD_CLK_CONFIG_STOP;
            end
         end

         default: begin
            state_next = S_STOPPED;
            cfg_next   = SD_CLK_CONFIG_STOP;
         end
      endcase

      // Active follows the running configuration one cycle after it is
      // applied, and drops in the same update that leaves S_RUNNING.
      active_next = (state_reg == S_RUNNING) && (state_next == S_RUNNING) &&
                    (cfg_reg == i_speed_sel);
      busy_next   = init_pending_next | (state_next == S_INIT);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_reg        <= S_STOPPED;
         cfg_reg          <= SD_CLK_CONFIG_STOP;
         active_reg       <= 1'b0;
         busy_reg         <= 1'b0;
         done_reg         <= 1'b0;
         init_cnt_reg     <= 8'd0;
         init_pending_reg <= 1'b0;
         settled_reg      <= 1'b0;
         rise_d1_reg      <= 1'b0;
         rise_d2_reg      <= 1'b0;
      end else begin
         state_reg        <= state_next;
         cfg_reg          <= cfg_next;
         active_reg       <= active_next;
         busy_reg         <= busy_next;
         done_reg         <= done_next;
         init_cnt_reg     <= init_cnt_next;
         init_pending_reg <= init_pending_next;
         settled_reg      <= settled_next;
         rise_d1_reg      <= rise_eff;
         rise_d2_reg      <= rise_d1_reg;
      end
   end

   assign o_sd_clk_config = cfg_reg;
   assign o_clk_active    = active_reg;
   assign o_init_busy     = busy_reg;
   assign o_init_done     = done_reg;

endmodule

// File: tb/tb_sd_clk_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sd_clk_scheduler
// Bench for sd_clk_scheduler. A behavioural SD clock generator follows the
// DUT configuration: its strobes come one cycle ahead of each pin toggle, and
// the DIV_256 half period is shortened to 4 cycles to keep runs short. The
// generator also watches for high pulses cut short by a STOP, direct
// speed-to-speed switches, and restarts after fewer than two STOP cycles.
// -----------------------------------------------------------------------------
module tb_sd_clk_scheduler;

   localparam int INIT_CLOCKS = 80;

   logic       clk = 1'b0;
   logic       i_reset = 1'b1;
   logic [1:0] speed_sel = 2'd0;
   logic       init_start = 1'b0;
   logic       cmd_req = 1'b0;
   logic       dat_req = 1'b0;
   logic [1:0] o_sd_clk_config;
   logic       o_clk_active, o_init_busy, o_init_done;

   int   total = 0;
   int   bad = 0;

   // generator model and monitors
   int         gen_cnt = 0;
   logic       gen_pin = 1'b0;
   logic       str_rise, str_fall;
   int         init_rises = 0;
   int         trunc_events = 0;
   int         direct_err = 0;
   int         dwell_err = 0;
   int         zero_run = 100;
   logic [1:0] prev_cfg = 2'd0;
   bit         allow_trunc = 1'b0;

   always #5 clk = ~clk;

   sd_clk_scheduler #(.INIT_CLOCKS(INIT_CLOCKS)) dut (
      .i_clk                   (clk),
      .i_reset                 (i_reset),
      .i_speed_sel             (speed_sel),
      .i_init_start            (init_start),
      .i_cmd_req               (cmd_req),
      .i_dat_req               (dat_req),
      .i_sd_clk                (gen_pin),
      .i_sd_clk_strobe_rising  (str_rise),
      .i_sd_clk_strobe_falling (str_fall),
      .o_sd_clk_config         (o_sd_clk_config),
      .o_clk_active            (o_clk_active),
      .o_init_busy             (o_init_busy),
      .o_init_done             (o_init_done)
   );

   function automatic int half_of(input logic [1:0] c);
      case (c)
         2'd1:    return 4;
         2'd2:    return 2;
         default: return 1;
      endcase
   endfunction

   always_comb begin
      str_rise = 1'b0;
      str_fall = 1'b0;
      if (o_sd_clk_config != 2'd0 && gen_cnt >= half_of(o_sd_clk_config) - 1) begin
         if (gen_pin) str_fall = 1'b1;
         else         str_rise = 1'b1;
      end
   end

   always @(posedge clk) begin
      if (o_sd_clk_config == 2'd0) begin
         if (gen_pin && !allow_trunc) trunc_events <= trunc_events + 1;
         gen_cnt <= 0;
         gen_pin <= 1'b0;
      end else if (gen_cnt >= half_of(o_sd_clk_config) - 1) begin
         gen_cnt <= 0;
         gen_pin <= ~gen_pin;
      end else begin
         gen_cnt <= gen_cnt + 1;
      end
      if (str_rise && o_sd_clk_config == 2'd1) init_rises <= init_rises + 1;
      if (o_sd_clk_config != prev_cfg) begin
         if (prev_cfg != 2'd0 && o_sd_clk_config != 2'd0) direct_err <= direct_err + 1;
         if (prev_cfg == 2'd0 && o_sd_clk_config != 2'd1 && zero_run < 2 && !allow_trunc)
            dwell_err <= dwell_err + 1;
      end
      prev_cfg <= o_sd_clk_config;
      zero_run <= (o_sd_clk_config == 2'd0) ? zero_run + 1 : 0;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Follows one power-up sequence already running at DIV_256 and reports
   // what it saw; callers do the comparisons.
   task automatic wait_init_done(output int rises, output int done_pulses,
                                 output bit stop_after_fall, output bit timed_out);
      int base;
      bit armed;
      base = init_rises;
      armed = 1'b0;
      done_pulses = 0;
      stop_after_fall = 1'b0;
      timed_out = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (armed) begin
            stop_after_fall = (o_sd_clk_config == 2'd0) && o_init_done;
            armed = 1'b0;
         end
         if (o_init_done) done_pulses++;
         else if (done_pulses > 0) begin
            timed_out = 1'b0;
            break;
         end
         if (str_fall && o_sd_clk_config == 2'd1 && (init_rises - base) == INIT_CLOCKS)
            armed = 1'b1;
      end
      rises = init_rises - base;
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (o_sd_clk_config !== 2'd0) begin bad++; $display("FAIL reset_cfg: got %0d want 0", o_sd_clk_config); end
      total++; if (o_clk_active !== 1'b0) begin bad++; $display("FAIL reset_active: got %0b want 0", o_clk_active); end
      total++; if (o_init_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", o_init_busy); end
      total++; if (o_init_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", o_init_done); end
      i_reset = 1'b0;
      idle(4);
      $display("reset: cfg=%0d active=%0b busy=%0b", o_sd_clk_config, o_clk_active, o_init_busy);
   endtask

   task automatic test_init();
      int rises, pulses; bit saf, to, seen;
      init_start = 1'b1;
      @(negedge clk);
      init_start = 1'b0;
      total++; if (o_init_busy !== 1'b1) begin bad++; $display("FAIL init_busy_start: got %0b want 1", o_init_busy); end
      seen = (o_sd_clk_config == 2'd1);
      if (!seen) begin @(negedge clk); seen = (o_sd_clk_config == 2'd1); end
      total++; if (!seen) begin bad++; $display("FAIL init_cfg_div256: got %0d want 1", o_sd_clk_config); end
      wait_init_done(rises, pulses, saf, to);
      total++; if (to) begin bad++; $display("FAIL init_timeout: got timeout want done"); end
      total++; if (rises != INIT_CLOCKS) begin bad++; $display("FAIL init_rises: got %0d want %0d", rises, INIT_CLOCKS); end
      total++; if (pulses != 1) begin bad++; $display("FAIL init_done_width: got %0d want 1", pulses); end
      total++; if (!saf) begin bad++; $display("FAIL init_stop_after_fall: got 0 want 1"); end
      total++; if (o_init_busy !== 1'b0) begin bad++; $display("FAIL init_busy_end: got %0b want 0", o_init_busy); end
      $display("init: rises=%0d done_pulses=%0d", rises, pulses);
   endtask

   task automatic test_run_stop();
      int n, bad_act, highs; bit ok;
      speed_sel = 2'd2;
      cmd_req = 1'b1;
      @(negedge clk);
      total++; if (o_sd_clk_config !== 2'd2) begin bad++; $display("FAIL run_cfg: got %0d want 2", o_sd_clk_config); end
      @(negedge clk);
      total++; if (o_clk_active !== 1'b1) begin bad++; $display("FAIL run_active: got %0b want 1", o_clk_active); end
      n = $urandom_range(10, 40);
      bad_act = 0;
      repeat (n) begin @(negedge clk); if (!o_clk_active) bad_act++; end
      total++; if (bad_act != 0) begin bad++; $display("FAIL run_active_hold: got %0d inactive cycles want 0", bad_act); end
      cmd_req = 1'b0;
      @(negedge clk);
      total++; if (o_clk_active !== 1'b0) begin bad++; $display("FAIL stop_active: got %0b want 0", o_clk_active); end
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (o_sd_clk_config != 2'd2) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      total++; if (!ok || o_sd_clk_config !== 2'd0) begin bad++; $display("FAIL stop_cfg: got %0d want 0", o_sd_clk_config); end
      highs = 0;
      repeat (30) begin @(negedge clk); if (gen_pin || o_sd_clk_config != 2'd0) highs++; end
      total++; if (highs != 0) begin bad++; $display("FAIL stop_pin_idle: got %0d high cycles want 0", highs); end
      $display("run_stop: ran %0d cycles at DIV_4 then stopped", n);
   endtask

   task automatic test_speed_change();
      int zeros; bit ok;
      speed_sel = 2'd2;
      dat_req = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin @(negedge clk); if (o_clk_active) begin ok = 1'b1; break; end end
      total++; if (!ok) begin bad++; $display("FAIL chg_start_active: got 0 want 1"); end
      idle($urandom_range(5, 30));
      speed_sel = 2'd3;
      @(negedge clk);
      total++; if (o_clk_active !== 1'b0) begin bad++; $display("FAIL chg_active_drop: got %0b want 0", o_clk_active); end
      for (int i = 0; i < 20; i++) begin
         if (o_sd_clk_config != 2'd2) break;
         @(negedge clk);
      end
      total++; if (o_sd_clk_config !== 2'd0) begin bad++; $display("FAIL chg_stop_cfg: got %0d want 0", o_sd_clk_config); end
      zeros = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (o_sd_clk_config == 2'd0) zeros++;
         else break;
      end
      total++; if (o_sd_clk_config !== 2'd3) begin bad++; $display("FAIL chg_new_cfg: got %0d want 3", o_sd_clk_config); end
      total++; if (zeros < 2) begin bad++; $display("FAIL chg_stop_gap: got %0d cycles want >=2", zeros); end
      ok = 1'b0;
      for (int i = 0; i < 3; i++) begin @(negedge clk); if (o_clk_active) begin ok = 1'b1; break; end end
      total++; if (!ok) begin bad++; $display("FAIL chg_active_back: got 0 want 1"); end
      dat_req = 1'b0;
      idle(20);
      $display("speed_change: DIV_4 -> DIV_2 with %0d stopped cycles", zeros);
   endtask

   task automatic test_init_while_running();
      int rises, pulses; bit saf, to, ok;
      speed_sel = 2'd3;
      cmd_req = 1'b1;
      idle(6);
      init_start = 1'b1;
      @(negedge clk);
      init_start = 1'b0;
      total++; if (o_init_busy !== 1'b1) begin bad++; $display("FAIL irun_busy: got %0b want 1", o_init_busy); end
      for (int i = 0; i < 10; i++) begin if (o_sd_clk_config != 2'd3) break; @(negedge clk); end
      total++; if (o_sd_clk_config !== 2'd0) begin bad++; $display("FAIL irun_stop: got %0d want 0", o_sd_clk_config); end
      for (int i = 0; i < 10; i++) begin if (o_sd_clk_config != 2'd0) break; @(negedge clk); end
      total++; if (o_sd_clk_config !== 2'd1) begin bad++; $display("FAIL irun_div256: got %0d want 1", o_sd_clk_config); end
      wait_init_done(rises, pulses, saf, to);
      total++; if (to || rises != INIT_CLOCKS) begin bad++; $display("FAIL irun_rises: got %0d want %0d", rises, INIT_CLOCKS); end
      total++; if (pulses != 1) begin bad++; $display("FAIL irun_done_width: got %0d want 1", pulses); end
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); if (o_clk_active) begin ok = 1'b1; break; end end
      total++; if (!ok || o_sd_clk_config !== 2'd3) begin bad++; $display("FAIL irun_resume: got cfg %0d active %0b want 3/1", o_sd_clk_config, o_clk_active); end
      cmd_req = 1'b0;
      idle(20);
      $display("init_while_running: rises=%0d resumed cfg=3", rises);
   endtask

   task automatic test_simultaneous();
      int rises, pulses; bit saf, to, ok;
      speed_sel = 2'd2;
      init_start = 1'b1;
      cmd_req = 1'b1;
      @(negedge clk);
      init_start = 1'b0;
      total++; if (o_sd_clk_config !== 2'd2) begin bad++; $display("FAIL simul_run_cfg: got %0d want 2", o_sd_clk_config); end
      total++; if (o_init_busy !== 1'b1) begin bad++; $display("FAIL simul_busy: got %0b want 1", o_init_busy); end
      for (int i = 0; i < 20; i++) begin if (o_sd_clk_config == 2'd1) break; @(negedge clk); end
      wait_init_done(rises, pulses, saf, to);
      total++; if (to || rises != INIT_CLOCKS) begin bad++; $display("FAIL simul_rises: got %0d want %0d", rises, INIT_CLOCKS); end
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); if (o_clk_active) begin ok = 1'b1; break; end end
      total++; if (!ok || o_sd_clk_config !== 2'd2) begin bad++; $display("FAIL simul_resume: got cfg %0d active %0b want 2/1", o_sd_clk_config, o_clk_active); end
      cmd_req = 1'b0;
      idle(20);
      $display("simultaneous: init after brief run, rises=%0d", rises);
   endtask

   task automatic test_reset_mid_init();
      int base, rises, pulses, dones; bit saf, to;
      init_start = 1'b1;
      @(negedge clk);
      init_start = 1'b0;
      for (int i = 0; i < 5; i++) begin if (o_sd_clk_config == 2'd1) break; @(negedge clk); end
      base = init_rises;
      for (int i = 0; i < 1000; i++) begin if (init_rises - base >= 30) break; @(negedge clk); end
      total++; if (init_rises - base != 30) begin bad++; $display("FAIL rmid_reach30: got %0d want 30", init_rises - base); end
      allow_trunc = 1'b1;
      i_reset = 1'b1;
      @(negedge clk);
      total++; if (o_sd_clk_config !== 2'd0) begin bad++; $display("FAIL rmid_cfg: got %0d want 0", o_sd_clk_config); end
      total++; if (o_init_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %0b want 0", o_init_busy); end
      i_reset = 1'b0;
      dones = o_init_done ? 1 : 0;
      repeat (20) begin @(negedge clk); if (o_init_done) dones++; end
      allow_trunc = 1'b0;
      total++; if (dones != 0) begin bad++; $display("FAIL rmid_no_done: got %0d pulses want 0", dones); end
      init_start = 1'b1;
      @(negedge clk);
      init_start = 1'b0;
      for (int i = 0; i < 5; i++) begin if (o_sd_clk_config == 2'd1) break; @(negedge clk); end
      wait_init_done(rises, pulses, saf, to);
      total++; if (to || rises != INIT_CLOCKS) begin bad++; $display("FAIL rmid_fresh_rises: got %0d want %0d", rises, INIT_CLOCKS); end
      total++; if (pulses != 1 || !saf) begin bad++; $display("FAIL rmid_fresh_done: got pulses %0d stop %0b want 1/1", pulses, saf); end
      idle(5);
      $display("reset_mid_init: aborted at 30, fresh run rises=%0d", rises);
   endtask

   task automatic test_stop_speed();
      int cfg_bad, act_bad;
      speed_sel = 2'd0;
      cmd_req = 1'b1;
      cfg_bad = 0;
      act_bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (o_sd_clk_config != 2'd0) cfg_bad++;
         if (o_clk_active) act_bad++;
      end
      total++; if (cfg_bad != 0) begin bad++; $display("FAIL stopsel_cfg: got %0d nonzero cycles want 0", cfg_bad); end
      total++; if (act_bad != 0) begin bad++; $display("FAIL stopsel_active: got %0d active cycles want 0", act_bad); end
      cmd_req = 1'b0;
      idle(3);
      $display("stop_speed: 1000 cycles with speed STOP and request held");
   endtask

   // Random client/speed traffic against a settle model: once inputs have
   // been steady long enough, the clock must run at speed_sel exactly when
   // some client requests it and speed_sel is not STOP.
   task automatic test_random();
      int stable, checks;
      bit exp_on;
      logic [1:0] exp_cfg;
      stable = 0;
      checks = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (o_clk_active) begin
            total++; checks++;
            if (o_sd_clk_config !== speed_sel) begin bad++; $display("FAIL rnd_active_cfg @%0d: got %0d want %0d", cyc, o_sd_clk_config, speed_sel); end
         end
         if (stable >= 20) begin
            exp_on = (cmd_req | dat_req) && (speed_sel != 2'd0);
            exp_cfg = exp_on ? speed_sel : 2'd0;
            total++; checks++;
            if (o_clk_active !== exp_on) begin bad++; $display("FAIL rnd_active @%0d: got %0b want %0b", cyc, o_clk_active, exp_on); end
            total++; checks++;
            if (o_sd_clk_config !== exp_cfg) begin bad++; $display("FAIL rnd_cfg @%0d: got %0d want %0d", cyc, o_sd_clk_config, exp_cfg); end
         end
         if ($urandom_range(0, 15) == 0) begin
            speed_sel = 2'($urandom_range(0, 3));
            cmd_req = 1'($urandom_range(0, 1));
            dat_req = 1'($urandom_range(0, 1));
            stable = 0;
         end else begin
            stable++;
         end
      end
      cmd_req = 1'b0;
      dat_req = 1'b0;
      idle(30);
      total++; if (trunc_events != 0) begin bad++; $display("FAIL no_truncated_pulse: got %0d want 0", trunc_events); end
      total++; if (direct_err != 0) begin bad++; $display("FAIL no_direct_switch: got %0d want 0", direct_err); end
      total++; if (dwell_err != 0) begin bad++; $display("FAIL stop_dwell: got %0d short gaps want 0", dwell_err); end
      $display("random: %0d checks over 3000 cycles", checks);
   endtask

   initial begin
      test_reset();
      test_init();
      idle(5);
      test_run_stop();
      test_speed_change();
      test_init_while_running();
      test_simultaneous();
      test_reset_mid_init();
      test_stop_speed();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
